mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch stage (IF) and the memory
// stage (M) of a pipeline. One grant is serviced at a time; the winner's
// address, write-enable and write data are captured on grant entry and held
// on the mem_* outputs until mem_ready (or a wait timeout) ends the grant.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   if_req/if_addr          fetch read request (held until if_valid)
//   if_rdata/if_valid       fetched word and its one-cycle valid pulse
//   m_req/m_we/m_addr/m_wdata  memory-stage request (held until m_done)
//   m_rdata/m_done          load data and the one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  drive to the memory
//   mem_rdata/mem_ready     memory response
//   stall_if/stall_mem      pipeline freeze signals
//   mem_err                 pulses with valid/done when a grant timed out
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GNT_IF = 2'd1;
    localparam logic [1:0] GNT_M  = 2'd2;

    // The grant ends in the TIMEOUT-th cycle without mem_ready, i.e. when the
    // count of earlier waiting cycles already stands at TIMEOUT-1.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_m_q, last_m_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              m_done_q, m_done_d;
    logic              mem_err_q, mem_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

    logic              granted_s;
    logic              timeout_s;
    logic              finish_s;
    logic              pick_m_s;
    logic [DATA_W-1:0] rd_s;

    // Grant bookkeeping: completion/timeout detection and arbitration choice.
    always_comb begin
        granted_s = (state_q != IDLE);
        timeout_s = granted_s & ~mem_ready & (cnt_q == CNT_LAST);
        finish_s  = granted_s & (mem_ready | timeout_s);
        // M normally wins, but never twice in a row while fetch is waiting.
        pick_m_s  = m_req & ~(last_m_q & if_req);
        rd_s      = timeout_s ? {DATA_W{1'b0}} : mem_rdata;
    end

    // Next-state logic for the FSM, grant registers and response outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_m_d    = last_m_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        m_done_d    = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        m_rdata_d   = m_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_m_s) begin
                    state_d     = GNT_M;
                    cnt_d       = 4'd0;
                    last_m_d    = 1'b1;
                    mem_we_d    = m_we;
                    mem_addr_d  = m_addr;
                    mem_wdata_d = m_wdata;
                end else if (if_req) begin
                    state_d     = GNT_IF;
                    cnt_d       = 4'd0;
                    last_m_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GNT_IF, GNT_M: begin
                if (!mem_ready) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
                if (finish_s) begin
                    state_d   = IDLE;
                    mem_err_d = timeout_s;
                    if (state_q == GNT_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = rd_s;
                    end else begin
                        m_done_d = 1'b1;
                        // Stores leave the load-data register untouched.
                        if (!mem_we_q) begin
                            m_rdata_d = rd_s;
                        end else begin
                            m_rdata_d = m_rdata_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_en_d = (state_d != IDLE);
    end

    // State and output registers; reset forces everything idle immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_m_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_valid_q  <= 1'b0;
            m_done_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            m_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_m_q    <= last_m_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            m_done_q    <= m_done_d;
            mem_err_q   <= mem_err_d;
            if_rdata_q  <= if_rdata_d;
            m_rdata_q   <= m_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign m_done    = m_done_q;
    assign mem_err   = mem_err_q;
    assign if_rdata  = if_rdata_q;
    assign m_rdata   = m_rdata_q;

    // Freeze a stage while its request is outstanding and not yet answered.
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = m_req & ~m_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model (who owns the memory, how many cycles the grant has lasted,
// what each requester should receive) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner 0 = nobody, 1 = fetch, 2 = memory stage.
    int                owner;
    bit                prev_was_m;
    int                grant_len;
    logic [ADDR_W-1:0] g_addr;
    logic              g_we;
    logic [DATA_W-1:0] g_wdata;
    logic              exp_if_valid, exp_m_done, exp_err;
    logic [DATA_W-1:0] exp_if_rdata, exp_m_rdata;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_done   (m_done),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .mem_err  (mem_err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner        = 0;
        prev_was_m   = 1'b0;
        grant_len    = 0;
        g_addr       = '0;
        g_we         = 1'b0;
        g_wdata      = '0;
        exp_if_valid = 1'b0;
        exp_m_done   = 1'b0;
        exp_err      = 1'b0;
        exp_if_rdata = '0;
        exp_m_rdata  = '0;
    endtask

    // Predict the next cycle from the inputs present in the current cycle.
    task automatic model_step();
        bit timed_out;
        logic [DATA_W-1:0] data;
        exp_if_valid = 1'b0;
        exp_m_done   = 1'b0;
        exp_err      = 1'b0;
        if (owner == 0) begin
            if (m_req && !(prev_was_m && if_req)) begin
                owner = 2; prev_was_m = 1'b1; grant_len = 0;
                g_addr = m_addr; g_we = m_we; g_wdata = m_wdata;
            end else if (if_req) begin
                owner = 1; prev_was_m = 1'b0; grant_len = 0;
                g_addr = if_addr; g_we = 1'b0;
            end
        end else begin
            grant_len++;
            if (mem_ready || grant_len == TIMEOUT) begin
                timed_out = !mem_ready;
                data      = timed_out ? 32'h0 : mem_rdata;
                exp_err   = timed_out;
                if (owner == 1) begin
                    exp_if_valid = 1'b1;
                    exp_if_rdata = data;
                end else begin
                    exp_m_done = 1'b1;
                    if (!g_we) exp_m_rdata = data;
                end
                owner = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_value("mem_en", mem_en, (owner != 0));
        if (owner != 0) begin
            check_value("mem_addr", mem_addr, g_addr);
            check_value("mem_we", mem_we, g_we);
            if (g_we) check_value("mem_wdata", mem_wdata, g_wdata);
        end
        check_value("if_valid", if_valid, exp_if_valid);
        check_value("m_done", m_done, exp_m_done);
        check_value("mem_err", mem_err, exp_err);
        check_value("if_rdata", if_rdata, exp_if_rdata);
        check_value("m_rdata", m_rdata, exp_m_rdata);
    endtask

    task automatic check_reset_state();
        check_value("rst_mem_en", mem_en, 32'h0);
        check_value("rst_mem_we", mem_we, 32'h0);
        check_value("rst_mem_addr", mem_addr, 32'h0);
        check_value("rst_mem_wdata", mem_wdata, 32'h0);
        check_value("rst_if_valid", if_valid, 32'h0);
        check_value("rst_m_done", m_done, 32'h0);
        check_value("rst_mem_err", mem_err, 32'h0);
        check_value("rst_if_rdata", if_rdata, 32'h0);
        check_value("rst_m_rdata", m_rdata, 32'h0);
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic tick();
        #1;
        check_value("stall_if", stall_if, if_req & ~exp_if_valid);
        check_value("stall_mem", stall_mem, m_req & ~exp_m_done);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        model_reset();
        check_reset_state();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; m_req = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        model_reset();

        // Single fetch, memory answers one cycle after mem_en rises.
        reset_dut();
        if_req = 1'b1; if_addr = 7'd5;
        tick();
        check_value("f1_addr", mem_addr, 32'd5);
        check_value("f1_we", mem_we, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h8C010004;
        tick();
        check_value("f1_valid", if_valid, 32'd1);
        check_value("f1_rdata", if_rdata, 32'h8C010004);
        #1 check_value("f1_stall_if", stall_if, 32'd0);
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Both requesters from reset, memory always ready: M, IF, M, IF.
        reset_dut();
        if_req = 1'b1; if_addr = 7'd1; m_req = 1'b1; m_we = 1'b0; m_addr = 7'd2;
        mem_ready = 1'b1; mem_rdata = 32'h11112222;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) begin
                check_value("alt_addr", mem_addr, (k % 4 == 1) ? 32'd2 : 32'd1);
            end else begin
                check_value("alt_m_done", m_done, (k % 4 == 2) ? 32'd1 : 32'd0);
                check_value("alt_if_valid", if_valid, (k % 4 == 0) ? 32'd1 : 32'd0);
            end
        end

        // Store: address and data on the memory port, m_rdata unchanged.
        if_req = 1'b0; m_req = 1'b1; m_we = 1'b1; m_addr = 7'h10; m_wdata = 32'hDEADBEEF;
        mem_ready = 1'b0;
        tick();
        check_value("st_we", mem_we, 32'd1);
        check_value("st_addr", mem_addr, 32'h10);
        check_value("st_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1'b1; mem_rdata = 32'h33334444;
        tick();
        check_value("st_done", m_done, 32'd1);
        check_value("st_rdata_hold", m_rdata, 32'h11112222);
        m_req = 1'b0; m_we = 1'b0;

        // Memory never answers a fetch: timeout after 15 grant cycles.
        if_req = 1'b1; if_addr = 7'd9; mem_ready = 1'b0;
        tick();
        for (int i = 1; i <= TIMEOUT; i++) begin
            check_value("to_busy", mem_en, 32'd1);
            tick();
        end
        check_value("to_valid", if_valid, 32'd1);
        check_value("to_err", mem_err, 32'd1);
        check_value("to_rdata", if_rdata, 32'd0);
        check_value("to_idle", mem_en, 32'd0);
        if_req = 1'b0;
        tick();

        // Reset in the second cycle of a memory-stage grant.
        m_req = 1'b1; m_we = 1'b0; m_addr = 7'd3; mem_ready = 1'b0;
        tick();
        tick();
        check_value("mr_en_before", mem_en, 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(negedge clock);
        check_value("mr_no_done", m_done, 32'd0);
        check_value("mr_en_low", mem_en, 32'd0);
        reset = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h5A5A0001;
        tick();
        check_value("mr_regrant", mem_en, 32'd1);
        tick();
        check_value("mr_done", m_done, 32'd1);
        check_value("mr_rdata", m_rdata, 32'h5A5A0001);
        m_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Randomized traffic, with occasional long memory stalls and drops.
        for (int c = 0; c < 4000; c++) begin
            if (exp_if_valid || !if_req) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = ADDR_W'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (exp_m_done || !m_req) begin
                m_req   = ($urandom_range(0, 1) == 1);
                m_we    = ($urandom_range(0, 2) == 0);
                m_addr  = ADDR_W'($urandom);
                m_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                m_req = 1'b0;
            end
            mem_rdata = $urandom;
            mem_ready = (c % 400 < 370) ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
